// File: rtl/soc_rst_ctrl.sv
// soc_rst_ctrl: SoC reset sequencer.
// Waits for a filtered PLL lock, releases the peripheral reset and then the
// core reset after fixed delays, and re-enters reset on lock loss, software
// request or (optionally) watchdog expiry. The cause of the last reset is
// kept one-hot in rst_cause_o.
// The watchdog is built only when the macro SOC_RST_WDT_EN is defined.
module soc_rst_ctrl #(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       LOCK_FILT   = 8,
  parameter int unsigned       PERI_DLY    = 16,
  parameter int unsigned       CORE_DLY    = 16,
  parameter int unsigned       WDT_W       = 24,
  parameter logic [WDT_W-1:0]  WDT_LIMIT   = WDT_W'(24'hFF_FFFF)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_en_i,
  input  logic       wdt_kick_i,
  output logic       peri_rst_n_o,
  output logic       core_rst_n_o,
  output logic [3:0] rst_cause_o
);

  localparam int unsigned LOCK_W  = $clog2(LOCK_FILT + 1);
  localparam int unsigned DLY_MAX = (PERI_DLY > CORE_DLY) ? PERI_DLY : CORE_DLY;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
  localparam logic [DLY_W-1:0]  PERI_LAST = DLY_W'(PERI_DLY - 1);
  localparam logic [DLY_W-1:0]  CORE_LAST = DLY_W'(CORE_DLY - 1);

  localparam logic [3:0] CAUSE_EXT  = 4'b0001;
  localparam logic [3:0] CAUSE_LOCK = 4'b0010;
  localparam logic [3:0] CAUSE_SW   = 4'b0100;
  localparam logic [3:0] CAUSE_WDT  = 4'b1000;

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_PERI,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_LOCK,
    EV_SW,
    EV_WDT
  } evt_t;

  state_t                   state;
  state_t                   state_nxt;
  evt_t                     evt;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     locked_s;
  logic [LOCK_W-1:0]        lock_cnt;
  logic [DLY_W-1:0]         dly_cnt;
  logic                     wdt_expire;
  logic                     peri_nxt;
  logic                     core_nxt;
  logic [3:0]               cause_nxt;

  // Bring the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbours, which is what makes the chain shift.
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef SOC_RST_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;

  // Expiry is the edge on which the count would reach the limit; a kick in
  // the same cycle takes precedence.
  assign wdt_expire = (state == S_RUN) && wdt_en_i && !wdt_kick_i &&
                      (wdt_cnt == WDT_LIMIT - 1'b1);

  // Watchdog counter: runs only in S_RUN, cleared on entry and on a kick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if ((state != S_RUN) || (state_nxt != S_RUN) || wdt_kick_i) begin
      wdt_cnt <= '0;
    end else if (wdt_en_i) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_wdt;

  assign wdt_expire = 1'b0;
  assign unused_wdt = ^{wdt_en_i, wdt_kick_i, WDT_LIMIT};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; exit events are ordered lock loss > software > watchdog.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    evt       = EV_NONE;
    case (state)
      S_WAIT_LOCK: begin
        if (locked_s && (lock_cnt == LOCK_LAST)) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          evt       = EV_LOCK;
        end else if (dly_cnt == PERI_LAST) begin
          state_nxt = S_PERI;
        end
      end
      S_PERI: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          evt       = EV_LOCK;
        end else if (sw_rst_req_i) begin
          state_nxt = S_HOLD;
          evt       = EV_SW;
        end else if (dly_cnt == CORE_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          evt       = EV_LOCK;
        end else if (sw_rst_req_i) begin
          state_nxt = S_HOLD;
          evt       = EV_SW;
        end else if (wdt_expire) begin
          state_nxt = S_HOLD;
          evt       = EV_WDT;
        end
      end
      default: begin
        state_nxt = S_WAIT_LOCK;
      end
    endcase
  end

  // Output decode from the next state, so the registered resets change on
  // the same edge as the state.
  always_comb begin
    peri_nxt  = (state_nxt == S_PERI) || (state_nxt == S_RUN);
    core_nxt  = (state_nxt == S_RUN);
    cause_nxt = rst_cause_o;
    case (evt)
      EV_LOCK: cause_nxt = CAUSE_LOCK;
      EV_SW:   cause_nxt = CAUSE_SW;
      EV_WDT:  cause_nxt = CAUSE_WDT;
      default: cause_nxt = rst_cause_o;
    endcase
  end

  // Registered reset outputs and cause record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peri_rst_n_o <= 1'b0;
      core_rst_n_o <= 1'b0;
      rst_cause_o  <= CAUSE_EXT;
    end else begin
      peri_rst_n_o <= peri_nxt;
      core_rst_n_o <= core_nxt;
      rst_cause_o  <= cause_nxt;
    end
  end

  // Lock filter: counts consecutive locked cycles while waiting for lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if ((state == S_WAIT_LOCK) && (state_nxt == S_WAIT_LOCK) && locked_s) begin
      lock_cnt <= lock_cnt + 1'b1;
    end else begin
      lock_cnt <= '0;
    end
  end

  // Release delay counter for S_HOLD and S_PERI; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if (state_nxt != state) begin
      dly_cnt <= '0;
    end else if ((state == S_HOLD) || (state == S_PERI)) begin
      dly_cnt <= dly_cnt + 1'b1;
    end else begin
      dly_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_soc_rst_ctrl.sv
// Testbench for soc_rst_ctrl: table of directed vectors for the release
// sequence, software request, lock loss and lock glitch, plus hand-written
// sequences for asynchronous reset and the watchdog (SOC_RST_WDT_EN).
module tb_soc_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic       wdt_en_i;
  logic       wdt_kick_i;
  logic       peri_rst_n_o;
  logic       core_rst_n_o;
  logic [3:0] rst_cause_o;

  int checks = 0;
  int errors = 0;

`ifdef SOC_RST_WDT_EN
  localparam bit WDT_BUILT = 1'b1;
`else
  localparam bit WDT_BUILT = 1'b0;
`endif

  always #5 clk = ~clk;

  soc_rst_ctrl #(
    .SYNC_STAGES (2),
    .LOCK_FILT   (8),
    .PERI_DLY    (16),
    .CORE_DLY    (16),
    .WDT_W       (24),
    .WDT_LIMIT   (24'd1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked_i (pll_locked_i),
    .sw_rst_req_i (sw_rst_req_i),
    .wdt_en_i     (wdt_en_i),
    .wdt_kick_i   (wdt_kick_i),
    .peri_rst_n_o (peri_rst_n_o),
    .core_rst_n_o (core_rst_n_o),
    .rst_cause_o  (rst_cause_o)
  );

  typedef struct {
    string      name;
    int         edges;
    logic       lock;
    logic       sw;
    logic       peri;
    logic       core;
    logic [3:0] cause;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input int edges, input logic lock,
                     input logic sw, input logic peri, input logic core,
                     input logic [3:0] cause);
    vec_t v;
    v.name  = name;
    v.edges = edges;
    v.lock  = lock;
    v.sw    = sw;
    v.peri  = peri;
    v.core  = core;
    v.cause = cause;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic peri, input logic core,
                            input logic [3:0] cause);
    check({name, ".peri"},  32'(peri_rst_n_o), 32'(peri));
    check({name, ".core"},  32'(core_rst_n_o), 32'(core));
    check({name, ".cause"}, 32'(rst_cause_o),  32'(cause));
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic kick_pulse();
    wdt_kick_i = 1'b1;
    step(1);
    wdt_kick_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c_wdt;
    c_wdt = WDT_BUILT ? 4'b1000 : 4'b0001;

    // Power-up through software request, lock loss, relock, glitch, and
    // simultaneous lock loss + software request.
    add("pwr_pre_peri",   25, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    add("pwr_peri",        1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
    add("pwr_pre_core",   15, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
    add("pwr_core",        1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);
    add("run_idle",        5, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);
    add("sw_req",          1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    add("sw_hold_a",       4, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    add("sw_in_hold",      1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    add("sw_pre_peri",    10, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    add("sw_peri",         1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
    add("sw_pre_core",    15, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
    add("sw_core",         1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100);
    add("drop_e1",         1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100);
    add("drop_e2",         1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100);
    add("drop_e3",         1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("lock_low",       10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("relock_pre_peri",25, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("relock_peri",     1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010);
    add("relock_pre_core",15, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010);
    add("relock_core",     1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010);
    add("drop2",          12, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("glitch_hi",       5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("glitch_lo",       5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("glitch_pre_peri",25, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
    add("glitch_peri",     1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010);
    add("glitch_pre_core",15, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010);
    add("glitch_core",     1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010);
    add("both_a",          2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
    add("both_b",          1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);

    rst_n        = 1'b1;
    pll_locked_i = 1'b1;
    sw_rst_req_i = 1'b0;
    wdt_en_i     = 1'b0;
    wdt_kick_i   = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check_outs("reset", 1'b0, 1'b0, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      pll_locked_i = vecs[i].lock;
      sw_rst_req_i = vecs[i].sw;
      step(vecs[i].edges);
      check_outs(vecs[i].name, vecs[i].peri, vecs[i].core, vecs[i].cause);
    end
    sw_rst_req_i = 1'b0;
    check("both_state", 32'(dut.state), 32'd0);

    // Asynchronous reset in the middle of S_PERI.
    pll_locked_i = 1'b1;
    step(25);
    check_outs("mid_pre_peri", 1'b0, 1'b0, 4'b0010);
    step(1);
    check_outs("mid_peri", 1'b1, 1'b0, 4'b0010);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    step(25);
    check_outs("rerun_pre_peri", 1'b0, 1'b0, 4'b0001);
    step(1);
    check_outs("rerun_peri", 1'b1, 1'b0, 4'b0001);
    step(15);
    check_outs("rerun_pre_core", 1'b1, 1'b0, 4'b0001);
    step(1);
    check_outs("rerun_core", 1'b1, 1'b1, 4'b0001);

    // Watchdog: enable held, no kick; expiry 1000 edges after S_RUN entry.
    wdt_en_i = 1'b1;
    step(999);
    check_outs("wdt_pre_exp", 1'b1, 1'b1, 4'b0001);
    step(1);
    check_outs("wdt_exp", !WDT_BUILT, !WDT_BUILT, c_wdt);
    step(16);
    check_outs("wdt_peri", 1'b1, !WDT_BUILT, c_wdt);
    step(16);
    check_outs("wdt_core", 1'b1, 1'b1, c_wdt);

    // Kick every 900 cycles: no reset for over 10000 cycles.
    for (int i = 0; i < 12; i++) begin
      step(899);
      kick_pulse();
      check_outs($sformatf("wdt_kick%0d", i), 1'b1, 1'b1, c_wdt);
    end

    // Kick landing in the expiry cycle wins; expiry follows a full period later.
    step(999);
    check_outs("wdt_edge_pre", 1'b1, 1'b1, c_wdt);
    kick_pulse();
    check_outs("wdt_edge_kick", 1'b1, 1'b1, c_wdt);
    step(999);
    check_outs("wdt_after_kick", 1'b1, 1'b1, c_wdt);
    step(1);
    check_outs("wdt_exp2", !WDT_BUILT, !WDT_BUILT, c_wdt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
